rc4_ksa_engine: RTL and testbench

Parametrised RC4 key-scheduling engine that drives a single-port synchronous state RAM. It optionally fills the RAM with the identity permutation, then runs the full KSA swap loop with a runtime-selectable key length and a configurable RAM read latency. It sits between the key-search controller and the S-box RAM, and replaces the fixed 3-byte, fixed-latency shuffler.

---
 rtl/rc4_pkg.sv | 31 +++
 rtl/rc4_key_index.sv | 34 +++
 rtl/rc4_ksa_engine.sv | 172 +++++++++++++++++
 tb/tb_rc4_ksa_engine.sv | 460 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rc4_pkg.sv
// Shared definitions for the RC4 key-scheduling engine.
//   rc4_ksa_state_t : controller states
//   rc4_next_j      : KSA index update, (j + si + kb) reduced to 'width' bits
package rc4_pkg;

    typedef enum logic [3:0] {
        IDLE,
        INIT,
        RD_I,
        WAIT_I,
        CAP_I,
        RD_J,
        WAIT_J,
        CAP_J,
        WR_I,
        WR_J,
        DONE
    } rc4_ksa_state_t;

    function automatic logic [31:0] rc4_next_j(
        input logic [31:0] j,
        input logic [31:0] si,
        input logic [31:0] kb,
        input int unsigned width
    );
        logic [31:0] mask;
        mask = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
        return (j + si + kb) & mask;
    endfunction

endpackage

// File: rtl/rc4_key_index.sv
// Wrapping key-byte counter for the RC4 KSA.
//   clk, reset : clock, synchronous active-high reset
//   clr        : force k to 0
//   inc        : advance k, wrapping to 0 after len-1
//   len        : active key length in bytes
//   k          : current key byte index
module rc4_key_index
    import rc4_pkg::*;
#(
    parameter int MAX_KEY_BYTES = 16,
    localparam int KL_W         = $clog2(MAX_KEY_BYTES + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clr,
    input  logic            inc,
    input  logic [KL_W-1:0] len,
    output logic [KL_W-1:0] k
);

    logic [KL_W-1:0] k_next;

    // k never exceeds len-1 <= MAX_KEY_BYTES-1, so k+1 always fits in KL_W.
    assign k_next = k + KL_W'(1);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            k <= '0;
        end else if (inc) begin
            k <= (k_next == len) ? '0 : k_next;
        end
    end

endmodule

// File: rtl/rc4_ksa_engine.sv
// RC4 key-scheduling engine driving a single-port synchronous S-box RAM.
// Optionally fills the RAM with the identity permutation, then runs the
// full KSA swap loop with a runtime key length.
//   clk, reset          : clock, synchronous active-high reset
//   start               : run request, edge-armed (held high never retriggers)
//   init_en             : identity fill before the shuffle
//   key_len, key        : active key length and key bytes (key[k] is byte k)
//   busy, done, error   : status; done is a one-cycle pulse, error is sticky
//   ram_addr/wdata/we   : RAM request, Moore outputs
//   ram_rdata           : RAM read data, valid RD_LATENCY cycles after addr
module rc4_ksa_engine
    import rc4_pkg::*;
#(
    parameter int DATA_W        = 8,
    parameter int MAX_KEY_BYTES = 16,
    parameter int RD_LATENCY    = 1,
    localparam int KL_W         = $clog2(MAX_KEY_BYTES + 1)
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                start,
    input  logic                                init_en,
    input  logic [KL_W-1:0]                     key_len,
    input  logic [MAX_KEY_BYTES-1:0][DATA_W-1:0] key,
    output logic                                busy,
    output logic                                done,
    output logic                                error,
    output logic [DATA_W-1:0]                   ram_addr,
    output logic [DATA_W-1:0]                   ram_wdata,
    output logic                                ram_we,
    input  logic [DATA_W-1:0]                   ram_rdata
);

    localparam int WC_W                   = $clog2(RD_LATENCY + 1);
    localparam logic [DATA_W-1:0] I_LAST  = '1;
    localparam logic [WC_W-1:0] WAIT_LOAD = WC_W'(RD_LATENCY - 1);

    rc4_ksa_state_t  state, nstate;
    logic [DATA_W-1:0] i, j, si, sj;
    logic [WC_W-1:0]   wait_cnt;
    logic [KL_W-1:0]   key_len_q;
    logic [KL_W-1:0]   k;
    logic [DATA_W-1:0] key_byte;
    logic              armed;
    logic              accept;
    logic              bad_len;

    assign accept  = (state == IDLE) && start && armed;
    assign bad_len = (key_len == '0) || (key_len > KL_W'(MAX_KEY_BYTES));

    rc4_key_index #(
        .MAX_KEY_BYTES(MAX_KEY_BYTES)
    ) u_key_index (
        .clk  (clk),
        .reset(reset),
        .clr  (accept),
        .inc  (state == WR_J),
        .len  (key_len_q),
        .k    (k)
    );

    // Mux-by-compare keeps the index width independent of KL_W.
    always_comb begin
        key_byte = '0;
        for (int unsigned b = 0; b < MAX_KEY_BYTES; b++) begin
            if (k == KL_W'(b)) key_byte = key[b];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            i         <= '0;
            j         <= '0;
            si        <= '0;
            sj        <= '0;
            wait_cnt  <= '0;
            key_len_q <= '0;
            armed     <= 1'b0;
            error     <= 1'b0;
        end else begin
            state <= nstate;
            if (accept)      armed <= 1'b0;
            else if (!start) armed <= 1'b1;

            case (state)
                IDLE: begin
                    if (accept) begin
                        i         <= '0;
                        j         <= '0;
                        key_len_q <= key_len;
                        error     <= bad_len;
                    end
                end
                INIT:           i        <= i + DATA_W'(1);
                RD_I, RD_J:     wait_cnt <= WAIT_LOAD;
                WAIT_I, WAIT_J: wait_cnt <= wait_cnt - WC_W'(1);
                CAP_I: begin
                    si <= ram_rdata;
                    j  <= DATA_W'(rc4_next_j(32'(j), 32'(ram_rdata), 32'(key_byte), DATA_W));
                end
                CAP_J:          sj       <= ram_rdata;
                WR_J:           i        <= i + DATA_W'(1);
                default: ;
            endcase
        end
    end

    always_comb begin
        nstate    = state;
        ram_addr  = '0;
        ram_wdata = '0;
        ram_we    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (bad_len)      nstate = DONE;
                    else if (init_en) nstate = INIT;
                    else              nstate = RD_I;
                end
            end
            INIT: begin
                ram_addr  = i;
                ram_wdata = i;
                ram_we    = 1'b1;
                if (i == I_LAST) nstate = RD_I;
            end
            RD_I: begin
                ram_addr = i;
                nstate   = (RD_LATENCY == 1) ? CAP_I : WAIT_I;
            end
            WAIT_I: begin
                ram_addr = i;
                if (wait_cnt == WC_W'(1)) nstate = CAP_I;
            end
            CAP_I: begin
                ram_addr = i;
                nstate   = RD_J;
            end
            RD_J: begin
                ram_addr = j;
                nstate   = (RD_LATENCY == 1) ? CAP_J : WAIT_J;
            end
            WAIT_J: begin
                ram_addr = j;
                if (wait_cnt == WC_W'(1)) nstate = CAP_J;
            end
            CAP_J: begin
                ram_addr = j;
                nstate   = WR_I;
            end
            WR_I: begin
                ram_addr  = i;
                ram_wdata = sj;
                ram_we    = 1'b1;
                nstate    = WR_J;
            end
            WR_J: begin
                ram_addr  = j;
                ram_wdata = si;
                ram_we    = 1'b1;
                nstate    = (i == I_LAST) ? DONE : RD_I;
            end
            DONE:    nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_rc4_ksa_engine.sv
// Bench for rc4_ksa_engine: three 8-bit engines (read latency 1, 2, 3)
// share stimulus and run side by side; a 4-bit engine covers the small
// configuration. Results are checked against a software RC4 KSA.
module tb_rc4_ksa_engine;
    import rc4_pkg::*;

    typedef int unsigned sarr_t [256];
    typedef int unsigned karr_t [16];
    typedef struct { int a; int d; } wr_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    // 8-bit engines
    logic             start8, init8;
    logic [4:0]       klen8;
    logic [15:0][7:0] key8;
    logic [2:0]       busy8, done8, err8, we8;
    logic [2:0][7:0]  addr8, wdata8;
    logic [7:0]       rd0, rd1, rd2, p1a, p2a, p2b;
    logic [7:0]       mem0 [256];
    logic [7:0]       mem1 [256];
    logic [7:0]       mem2 [256];

    // 4-bit engine
    logic            start4, init4;
    logic [1:0]      klen4;
    logic [1:0][3:0] key4;
    logic            busy4, done4, err4, we4;
    logic [3:0]      addr4, wdata4, rd4;
    logic [3:0]      mem4 [16];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc [3];
    int we_cnt;
    logic [2:0] err_at1;
    wr_t wlog [$];

    rc4_ksa_engine #(.DATA_W(8), .MAX_KEY_BYTES(16), .RD_LATENCY(1)) u8l1 (
        .clk(clk), .reset(reset), .start(start8), .init_en(init8), .key_len(klen8), .key(key8),
        .busy(busy8[0]), .done(done8[0]), .error(err8[0]),
        .ram_addr(addr8[0]), .ram_wdata(wdata8[0]), .ram_we(we8[0]), .ram_rdata(rd0));

    rc4_ksa_engine #(.DATA_W(8), .MAX_KEY_BYTES(16), .RD_LATENCY(2)) u8l2 (
        .clk(clk), .reset(reset), .start(start8), .init_en(init8), .key_len(klen8), .key(key8),
        .busy(busy8[1]), .done(done8[1]), .error(err8[1]),
        .ram_addr(addr8[1]), .ram_wdata(wdata8[1]), .ram_we(we8[1]), .ram_rdata(rd1));

    rc4_ksa_engine #(.DATA_W(8), .MAX_KEY_BYTES(16), .RD_LATENCY(3)) u8l3 (
        .clk(clk), .reset(reset), .start(start8), .init_en(init8), .key_len(klen8), .key(key8),
        .busy(busy8[2]), .done(done8[2]), .error(err8[2]),
        .ram_addr(addr8[2]), .ram_wdata(wdata8[2]), .ram_we(we8[2]), .ram_rdata(rd2));

    rc4_ksa_engine #(.DATA_W(4), .MAX_KEY_BYTES(2), .RD_LATENCY(1)) u4 (
        .clk(clk), .reset(reset), .start(start4), .init_en(init4), .key_len(klen4), .key(key4),
        .busy(busy4), .done(done4), .error(err4),
        .ram_addr(addr4), .ram_wdata(wdata4), .ram_we(we4), .ram_rdata(rd4));

    // Synchronous RAM models with the matching read latencies
    always @(posedge clk) begin
        if (we8[0]) mem0[addr8[0]] <= wdata8[0];
        rd0 <= mem0[addr8[0]];
    end
    always @(posedge clk) begin
        if (we8[1]) mem1[addr8[1]] <= wdata8[1];
        p1a <= mem1[addr8[1]];
        rd1 <= p1a;
    end
    always @(posedge clk) begin
        if (we8[2]) mem2[addr8[2]] <= wdata8[2];
        p2a <= mem2[addr8[2]];
        p2b <= p2a;
        rd2 <= p2b;
    end
    always @(posedge clk) begin
        if (we4) mem4[addr4] <= wdata4;
        rd4 <= mem4[addr4];
    end

    // ---------------- reference model ----------------
    function automatic sarr_t ident();
        sarr_t r;
        for (int a = 0; a < 256; a++) r[a] = a;
        return r;
    endfunction

    function automatic sarr_t ksa(input sarr_t s_in, input karr_t kb, input int unsigned len,
                                  input int unsigned n);
        sarr_t s;
        int unsigned jj, t;
        s  = s_in;
        jj = 0;
        for (int unsigned ii = 0; ii < n; ii++) begin
            jj    = (jj + s[ii] + kb[ii % len]) % n;
            t     = s[ii];
            s[ii] = s[jj];
            s[jj] = t;
        end
        return s;
    endfunction

    function automatic int exp_cyc(input int init, input int lat, input int n);
        return init * n + n * (4 + 2 * lat) + 1;
    endfunction

    function automatic karr_t karr8();
        karr_t r;
        for (int b = 0; b < 16; b++) r[b] = key8[b];
        return r;
    endfunction

    function automatic karr_t karr4();
        karr_t r;
        for (int b = 0; b < 16; b++) r[b] = 0;
        r[0] = key4[0];
        r[1] = key4[1];
        return r;
    endfunction

    function automatic sarr_t get_mem8(input int n);
        sarr_t r;
        for (int a = 0; a < 256; a++) begin
            case (n)
                0:       r[a] = mem0[a];
                1:       r[a] = mem1[a];
                default: r[a] = mem2[a];
            endcase
        end
        return r;
    endfunction

    function automatic sarr_t get_mem4();
        sarr_t r;
        for (int a = 0; a < 256; a++) r[a] = 0;
        for (int a = 0; a < 16; a++) r[a] = mem4[a];
        return r;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic go8();
        start8 = 1'b0;
        @(negedge clk);
        start8 = 1'b1;
    endtask

    task automatic run8(input int budget, input bit hold, input bit log_en);
        int cnt;
        logic [2:0] seen;
        cnt  = 0;
        seen = '0;
        we_cnt = 0;
        err_at1 = 'x;
        wlog.delete();
        for (int n = 0; n < 3; n++) cyc[n] = -1;
        go8();
        while (cnt < budget && seen != 3'b111) begin
            @(negedge clk);
            cnt++;
            if (cnt == 1) begin
                err_at1 = err8;
                if (!hold) start8 = 1'b0;
            end
            if (we8[0]) begin
                we_cnt++;
                if (log_en) wlog.push_back('{int'(addr8[0]), int'(wdata8[0])});
            end
            for (int n = 0; n < 3; n++) begin
                if (done8[n] && !seen[n]) begin
                    seen[n] = 1'b1;
                    cyc[n]  = cnt;
                end
            end
        end
    endtask

    task automatic rand_key8();
        for (int b = 0; b < 16; b++) key8[b] = 8'($urandom);
    endtask

    task automatic check_mems(input string tag, input sarr_t exp [3]);
        sarr_t got;
        int bad;
        for (int n = 0; n < 3; n++) begin
            got = get_mem8(n);
            bad = -1;
            for (int a = 255; a >= 0; a--) if (got[a] != exp[n][a]) bad = a;
            n_cmp++;
            if (bad >= 0) begin
                n_bad++;
                $display("FAIL %s_ram L=%0d: s[%0d] got %0d, expected %0d",
                         tag, n + 1, bad, got[bad], exp[n][bad]);
            end
        end
    endtask

    task automatic check_cycles(input string tag, input int init);
        for (int n = 0; n < 3; n++) begin
            n_cmp++;
            if (cyc[n] !== exp_cyc(init, n + 1, 256)) begin
                n_bad++;
                $display("FAIL %s_cycles L=%0d: got %0d, expected %0d",
                         tag, n + 1, cyc[n], exp_cyc(init, n + 1, 256));
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset  = 1'b1;
        start8 = 1'b0; init8 = 1'b0; klen8 = '0; key8 = '0;
        start4 = 1'b0; init4 = 1'b0; klen4 = '0; key4 = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({busy8, done8, err8, we8} !== '0 || {addr8, wdata8} !== '0) begin
            n_bad++;
            $display("FAIL reset_8bit: busy=%b done=%b err=%b we=%b addr=%h wdata=%h, expected all 0",
                     busy8, done8, err8, we8, addr8, wdata8);
        end
        n_cmp++;
        if ({busy4, done4, err4, we4, addr4, wdata4} !== '0) begin
            n_bad++;
            $display("FAIL reset_4bit: busy=%b done=%b err=%b we=%b addr=%h wdata=%h, expected all 0",
                     busy4, done4, err4, we4, addr4, wdata4);
        end
    endtask

    task automatic test_basic();
        sarr_t exp [3];
        int bad;
        init8 = 1'b1;
        klen8 = 5'd1;
        rand_key8();
        key8[0] = 8'h05;
        run8(4000, 1'b0, 1'b1);
        check_cycles("basic", 1);
        bad = (wlog.size() < 256) ? 256 : -1;
        for (int x = 255; x >= 0; x--) begin
            if (x < wlog.size() && (wlog[x].a != x || wlog[x].d != x)) bad = x;
        end
        n_cmp++;
        if (bad >= 0) begin
            n_bad++;
            $display("FAIL basic_init_write %0d: got log size %0d, expected s[x]=x for all 256 writes",
                     bad, wlog.size());
        end
        n_cmp++;
        if (wlog.size() < 258 || wlog[256].a != 0 || wlog[256].d != 5) begin
            n_bad++;
            $display("FAIL basic_swap_wr_i: got %0d writes (first swap write wrong), expected s[0]=0x05",
                     wlog.size());
        end
        n_cmp++;
        if (wlog.size() < 258 || wlog[257].a != 5 || wlog[257].d != 0) begin
            n_bad++;
            $display("FAIL basic_swap_wr_j: got %0d writes (second swap write wrong), expected s[5]=0x00",
                     wlog.size());
        end
        @(negedge clk);
        n_cmp++;
        if (busy8 !== 3'b000) begin
            n_bad++;
            $display("FAIL basic_busy_fall: got %b, expected 000", busy8);
        end
        for (int n = 0; n < 3; n++) exp[n] = ksa(ident(), karr8(), 1, 256);
        check_mems("basic", exp);
    endtask

    task automatic test_standard();
        sarr_t exp [3];
        init8 = 1'b1;
        klen8 = 5'd3;
        rand_key8();
        key8[0] = 8'h4B;
        key8[1] = 8'h65;
        key8[2] = 8'h79;
        run8(4000, 1'b0, 1'b0);
        @(negedge clk);
        check_cycles("standard", 1);
        for (int n = 0; n < 3; n++) exp[n] = ksa(ident(), karr8(), 3, 256);
        check_mems("standard", exp);
    endtask

    task automatic test_bad_key();
        logic [2:0] wes;
        for (int t = 0; t < 2; t++) begin
            klen8 = (t == 0) ? 5'd0 : 5'd17;
            init8 = 1'($urandom);
            wes   = '0;
            go8();
            for (int c = 1; c <= 4; c++) begin
                @(negedge clk);
                wes |= we8;
                if (c == 1) begin
                    start8 = 1'b0;
                    n_cmp++;
                    if (done8 !== 3'b111 || err8 !== 3'b111) begin
                        n_bad++;
                        $display("FAIL bad_len%0d_done: got done=%b error=%b, expected 111/111",
                                 klen8, done8, err8);
                    end
                end
                if (c == 2) begin
                    n_cmp++;
                    if (busy8 !== 3'b000) begin
                        n_bad++;
                        $display("FAIL bad_len%0d_busy: got %b, expected 000", klen8, busy8);
                    end
                end
                if (c == 4) begin
                    n_cmp++;
                    if (err8 !== 3'b111) begin
                        n_bad++;
                        $display("FAIL bad_len%0d_sticky: got %b, expected 111", klen8, err8);
                    end
                end
            end
            n_cmp++;
            if (wes !== 3'b000) begin
                n_bad++;
                $display("FAIL bad_len%0d_no_write: got we seen %b, expected 000", klen8, wes);
            end
        end
    endtask

    task automatic test_back_to_back();
        sarr_t exp [3];
        logic [2:0] busy_seen;
        int len;
        len = int'($urandom_range(1, 16));
        for (int n = 0; n < 3; n++) exp[n] = get_mem8(n);
        init8 = 1'b0;
        klen8 = 5'(len);
        rand_key8();
        for (int n = 0; n < 3; n++) exp[n] = ksa(exp[n], karr8(), len, 256);
        run8(4000, 1'b1, 1'b0);
        check_cycles("reentry", 0);
        n_cmp++;
        if (err_at1 !== 3'b000) begin
            n_bad++;
            $display("FAIL reentry_error_clear: got %b, expected 000", err_at1);
        end
        n_cmp++;
        if (we_cnt !== 512) begin
            n_bad++;
            $display("FAIL reentry_write_count: got %0d, expected 512", we_cnt);
        end
        busy_seen = '0;
        repeat (8) begin
            @(negedge clk);
            busy_seen |= busy8;
        end
        busy_seen = busy_seen | {2'b00, 1'b0};
        start8 = 1'b0;
        n_cmp++;
        if (busy_seen !== 3'b000) begin
            n_bad++;
            $display("FAIL reentry_no_retrigger: got busy %b after done, expected 000", busy_seen);
        end
        check_mems("reentry", exp);
    endtask

    task automatic test_reset_mid_run();
        sarr_t exp [3];
        int len;
        init8 = 1'b1;
        klen8 = 5'($urandom_range(1, 16));
        rand_key8();
        go8();
        for (int c = 1; c <= 321; c++) begin
            @(negedge clk);
            if (c == 1) start8 = 1'b0;
        end
        n_cmp++;
        if (we8[0] !== 1'b1 || addr8[0] !== 8'd10) begin
            n_bad++;
            $display("FAIL midrun_in_wr_i: got we=%b addr=%0d, expected we=1 addr=10", we8[0], addr8[0]);
        end
        reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({busy8, done8, err8, we8} !== '0 || {addr8, wdata8} !== '0) begin
            n_bad++;
            $display("FAIL midrun_reset_outputs: busy=%b done=%b err=%b we=%b addr=%h wdata=%h, expected all 0",
                     busy8, done8, err8, we8, addr8, wdata8);
        end
        reset = 1'b0;
        len   = int'($urandom_range(1, 16));
        klen8 = 5'(len);
        rand_key8();
        run8(4000, 1'b0, 1'b0);
        @(negedge clk);
        check_cycles("midrun_rerun", 1);
        for (int n = 0; n < 3; n++) exp[n] = ksa(ident(), karr8(), len, 256);
        check_mems("midrun_rerun", exp);
    endtask

    task automatic test_small();
        sarr_t exp, got;
        int cnt, iter, done_at, bad;
        init4 = 1'b1;
        klen4 = 2'd2;
        key4[0] = 4'($urandom);
        key4[1] = 4'($urandom);
        start4 = 1'b0;
        @(negedge clk);
        start4 = 1'b1;
        cnt = 0; iter = 0; done_at = -1;
        while (cnt < 500 && done_at < 0) begin
            @(negedge clk);
            cnt++;
            if (cnt == 1) start4 = 1'b0;
            if (u4.state == WR_J) begin
                n_cmp++;
                if (u4.k !== 2'(iter % 2)) begin
                    n_bad++;
                    $display("FAIL small_k_iter%0d: got %0d, expected %0d", iter, u4.k, iter % 2);
                end
                iter++;
            end
            if (done4) done_at = cnt;
        end
        n_cmp++;
        if (iter !== 16) begin
            n_bad++;
            $display("FAIL small_iterations: got %0d, expected 16", iter);
        end
        n_cmp++;
        if (done_at !== exp_cyc(1, 1, 16)) begin
            n_bad++;
            $display("FAIL small_cycles: got %0d, expected %0d", done_at, exp_cyc(1, 1, 16));
        end
        exp = ksa(ident(), karr4(), 2, 16);
        got = get_mem4();
        bad = -1;
        for (int a = 15; a >= 0; a--) if (got[a] != exp[a]) bad = a;
        n_cmp++;
        if (bad >= 0) begin
            n_bad++;
            $display("FAIL small_ram: s[%0d] got %0d, expected %0d", bad, got[bad], exp[bad]);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_standard();
        test_bad_key();
        test_back_to_back();
        test_reset_mid_run();
        test_small();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
